// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_port
// Description : Load/store unit memory port. Accepts one byte-addressed
//               load or store at a time and performs it on a word-wide,
//               single-cycle memory (combinational read, whole-word write).
//               Byte/halfword stores are done as read-modify-write.
//
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               req_valid/req_ready      - request handshake (ready only idle)
//               req_is_store, req_addr,
//               req_wdata, req_type      - request fields (funct3 size code)
//               resp_valid/data/err      - one-cycle completion pulse
//               mem_addr/we/wdata/rdata  - word memory port
//
// Config      : LSU_MISALIGN_CHECK_EN - when defined, misaligned halfword and
//               word accesses are rejected with resp_err instead of being
//               force-aligned.
//
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_port #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_type,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_RESP = 2'd3;

    localparam logic [2:0] c_T_B  = 3'b000;
    localparam logic [2:0] c_T_H  = 3'b001;
    localparam logic [2:0] c_T_W  = 3'b010;
    localparam logic [2:0] c_T_BU = 3'b100;
    localparam logic [2:0] c_T_HU = 3'b101;

    logic [1:0]        r_state;
    logic [ADDR_W+1:0] r_addr;      // byte address modulo the port's space
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;      // word read in RD (merge base / load data)
    logic [2:0]        r_type;
    logic              r_is_store;
    logic              r_err;

    logic              w_type_ok;
    logic              w_misalign;
    logic              w_err;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;
    logic              w_unused_addr_bits;

    // Address bits above the port's space are deliberately dropped.
    assign w_unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Unsigned sizes exist only for loads.
    always_comb begin
        case (req_type)
            c_T_B, c_T_H, c_T_W: w_type_ok = 1'b1;
            c_T_BU, c_T_HU:      w_type_ok = ~req_is_store;
            default:             w_type_ok = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        case (req_type)
            c_T_H, c_T_HU: w_misalign = req_addr[0];
            c_T_W:         w_misalign = |req_addr[1:0];
            default:       w_misalign = 1'b0;
        endcase
    end
`else
    // Misaligned halfword/word accesses are force-aligned by the lane logic.
    assign w_misalign = 1'b0;
`endif

    assign w_err = ~w_type_ok | w_misalign;

    // Lane selection: byte lane is addr[1:0]; halfword lane is addr[1], so
    // addr[0] is ignored for halfwords and addr[1:0] for words.
    assign w_byte = r_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];

    always_comb begin
        case (r_type)
            c_T_B:   w_load = {{24{w_byte[7]}}, w_byte};
            c_T_BU:  w_load = {24'd0, w_byte};
            c_T_H:   w_load = {{16{w_half[15]}}, w_half};
            c_T_HU:  w_load = {16'd0, w_half};
            default: w_load = r_word;
        endcase
    end

    // Store word: the word read in RD with the addressed lanes replaced.
    // Word stores skip RD and take the store data whole.
    always_comb begin
        w_merged = r_word;
        case (r_type)
            c_T_B: w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            c_T_H: begin
                if (r_addr[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0] = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_word     <= '0;
            r_type     <= '0;
            r_is_store <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr[ADDR_W+1:0];
                        r_wdata    <= req_wdata;
                        r_type     <= req_type;
                        r_is_store <= req_is_store;
                        r_err      <= w_err;
                        r_word     <= '0;
                        if (w_err) begin
                            r_state <= c_RESP;
                        end else if (req_is_store && (req_type == c_T_W)) begin
                            r_state <= c_WR;
                        end else begin
                            r_state <= c_RD;
                        end
                    end
                end
                c_RD: begin
                    r_word  <= mem_rdata;
                    r_state <= r_is_store ? c_WR : c_RESP;
                end
                c_WR:    r_state <= c_RESP;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = (r_state == c_RESP);
    assign resp_err   = resp_valid & r_err;
    assign resp_data  = (resp_valid && !r_is_store && !r_err) ? w_load : 32'd0;
    assign mem_addr   = r_addr[ADDR_W+1:2];
    assign mem_we     = (r_state == c_WR);
    assign mem_wdata  = mem_we ? w_merged : 32'd0;

endmodule
`default_nettype wire
